// File: rtl/serial_comparator_if.sv
// Request/result bundle for the chunked serial magnitude comparator.
// The master drives operands and start; the slave (comparator) returns status and flags.
interface serial_comparator_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
);
  localparam int unsigned CW = $clog2(N / CHUNK) + 1;

  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          is_signed;
  logic          busy;
  logic          done;
  logic          Lesser;
  logic          Greater;
  logic          Equal;
  logic [CW-1:0] chunks_used;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, Lesser, Greater, Equal, chunks_used
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, Lesser, Greater, Equal, chunks_used
  );
endinterface

// File: rtl/serial_comparator.sv
// Compares two N-bit operands CHUNK bits per cycle from the MSB end, stopping at the
// first differing chunk. All outputs are registered.
module serial_comparator #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_comparator_if.slave bus
);
  localparam int unsigned NCH = N / CHUNK;
  localparam int unsigned CW  = $clog2(NCH) + 1;

  localparam logic StIdle = 1'b0;
  localparam logic StCmp  = 1'b1;

  if (N < 2) begin : g_bad_n
    $error("serial_comparator: N must be at least 2");
  end
  if (CHUNK < 1 || CHUNK > N) begin : g_bad_chunk
    $error("serial_comparator: CHUNK must be in 1..N");
  end else if (N % CHUNK != 0) begin : g_bad_div
    $error("serial_comparator: CHUNK must divide N");
  end

  logic          state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          lt_q, lt_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic [CW-1:0] used_q, used_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  // Operands shift left each cycle so the chunk under test is always at the top.
  assign chunk_a = a_q[N-1 -: CHUNK];
  assign chunk_b = b_q[N-1 -: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    used_d  = used_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d = bus.a;
          b_d = bus.b;
          // Flipping the sign bits maps two's-complement order onto unsigned order.
          if (bus.is_signed) begin
            a_d[N-1] = ~bus.a[N-1];
            b_d[N-1] = ~bus.b[N-1];
          end
          idx_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (chunk_a != chunk_b) begin
          gt_d    = chunk_a > chunk_b;
          lt_d    = chunk_a < chunk_b;
          eq_d    = 1'b0;
          used_d  = idx_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (idx_q == CW'(NCH)) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          used_d  = idx_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      used_q  <= used_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.Lesser      = lt_q;
  assign bus.Greater     = gt_q;
  assign bus.Equal       = eq_q;
  assign bus.chunks_used = used_q;
endmodule
